ram_access_arbiter: RTL and testbench

//  Shares the single-port 128x64 data RAM between two requesters: port 0 (CPU load/store

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 21 ++
 rtl/ram_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the data RAM arbiter: RAM geometry and the access FSM encoding.
// Imported by the arbiter, the RAM wrapper and the bench.
package ram_arb_pkg;

    localparam int RAM_DEPTH  = 128;
    localparam int RAM_ADDR_W = 64;
    localparam int RAM_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selector; purely combinational.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Winner selection from the request vector and the previous winner
    always_comb begin
        grant_valid = |req;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a single-port data RAM between two requesters with round-robin arbitration,
// one access in flight at a time (grant -> RAM access -> response pulse).
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              ram_mem_read,
    output logic              ram_mem_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              grant_valid;
    logic              grant_idx;
    logic [ADDR_W-1:0] sel_addr;

    rr_arb2 u_rr_arb2 (
        .req         ({req1_valid, req0_valid}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_addr = grant_idx ? req1_addr : req0_addr;

    // Next-state, request latching and all outputs; every output is forced low while reset is high
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        owner_d        = owner_q;
        err_d          = err_q;
        rdata_d        = rdata_q;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        rsp0_valid     = 1'b0;
        rsp0_rdata     = '0;
        rsp0_err       = 1'b0;
        rsp1_valid     = 1'b0;
        rsp1_rdata     = '0;
        rsp1_err       = 1'b0;
        ram_mem_read   = 1'b0;
        ram_mem_write  = 1'b0;
        ram_address    = '0;
        ram_write_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req0_ready   = ~grant_idx;
                    req1_ready   = grant_idx;
                    write_d      = grant_idx ? req1_write : req0_write;
                    addr_d       = sel_addr;
                    wdata_d      = grant_idx ? req1_wdata : req0_wdata;
                    owner_d      = grant_idx;
                    err_d        = (sel_addr >= ADDR_W'(DEPTH));
                    last_grant_d = grant_idx;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                ram_address    = addr_q;
                ram_write_data = wdata_q;
                if (!err_q) begin
                    ram_mem_write = write_q;
                    ram_mem_read  = ~write_q;
                end else begin
                    ram_mem_write = 1'b0;
                    ram_mem_read  = 1'b0;
                end
                // Stores and out-of-range accesses return zero data
                if (!err_q && !write_q) begin
                    rdata_d = ram_read_data;
                end else begin
                    rdata_d = '0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = rdata_q;
                    rsp1_err   = err_q;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = rdata_q;
                    rsp0_err   = err_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            req0_ready     = 1'b0;
            req1_ready     = 1'b0;
            rsp0_valid     = 1'b0;
            rsp0_rdata     = '0;
            rsp0_err       = 1'b0;
            rsp1_valid     = 1'b0;
            rsp1_rdata     = '0;
            rsp1_err       = 1'b0;
            ram_mem_read   = 1'b0;
            ram_mem_write  = 1'b0;
            ram_address    = '0;
            ram_write_data = '0;
        end else begin
            ram_mem_read   = ram_mem_read;
        end
    end

    // State and latched-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomised scoreboard bench for ram_access_arbiter with a behavioural RAM and a
// transaction-level reference model (shadow memory, round-robin winner, 3-cycle slots).
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b1;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [63:0] req0_addr = 64'd0, req0_wdata = 64'd0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [63:0] req1_addr = 64'd0, req1_wdata = 64'd0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic        ram_mem_read, ram_mem_write;
    logic [63:0] ram_address, ram_write_data, ram_read_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          port;
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_mem [RAM_DEPTH];
    logic [63:0] ram [RAM_DEPTH];
    int          next_free = 0;
    logic        last_grant_m = 1'b1;

    ram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_mem_read(ram_mem_read), .ram_mem_write(ram_mem_write),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, write on posedge
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 64'(i * 100);
        end else if (ram_mem_write && ram_address < 64'(RAM_DEPTH)) begin
            ram[ram_address[6:0]] <= ram_write_data;
        end
    end
    assign ram_read_data = (ram_address < 64'(RAM_DEPTH)) ? ram[ram_address[6:0]] : 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts grants and RAM strobes, pushes expected responses
    always @(negedge clk) begin : model
        logic        e_rd, e_wr, e_r0, e_r1;
        logic [63:0] e_addr, e_wd;
        int          win;
        exp_t        ent;
        if (load_en) for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = 64'(i * 100);
        e_rd = 1'b0; e_wr = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
        e_addr = 64'd0; e_wd = 64'd0;
        if (reset) begin
            exp_q.delete();
            last_grant_m = 1'b1;
            next_free = cyc + 1;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].gcyc == cyc - 1) begin
                e_addr = exp_q[0].addr;
                e_wd   = exp_q[0].wdata;
                if (!exp_q[0].err) begin
                    e_wr = exp_q[0].write;
                    e_rd = !exp_q[0].write;
                    if (exp_q[0].write) ref_mem[exp_q[0].addr[6:0]] = exp_q[0].wdata;
                end
            end
            if (exp_q.size() > 0 && exp_q[0].gcyc < cyc - 2) begin
                checks++; errors++;
                $display("FAIL missing_rsp: port %0d granted at cycle %0d got no response", exp_q[0].port, exp_q[0].gcyc);
                void'(exp_q.pop_front());
            end
            if (cyc >= next_free && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) win = last_grant_m ? 0 : 1;
                else win = req0_valid ? 0 : 1;
                ent.port  = win;
                ent.write = win ? req1_write : req0_write;
                ent.addr  = win ? req1_addr : req0_addr;
                ent.wdata = win ? req1_wdata : req0_wdata;
                ent.err   = (ent.addr >= 64'(RAM_DEPTH));
                ent.rdata = (ent.err || ent.write) ? 64'd0 : ref_mem[ent.addr[6:0]];
                ent.gcyc  = cyc;
                exp_q.push_back(ent);
                last_grant_m = win[0];
                next_free = cyc + 3;
                e_r0 = (win == 0);
                e_r1 = (win == 1);
            end
        end
        chk("req0_ready", 64'(req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        chk("ram_strobes", {62'd0, ram_mem_write, ram_mem_read}, {62'd0, e_wr, e_rd});
        chk("ram_address", ram_address, e_addr);
        chk("ram_write_data", ram_write_data, e_wd);
    end

    // Monitor: pops the scoreboard whenever a response pulse appears
    always @(negedge clk) begin : monitor
        logic        v, e;
        logic [63:0] d;
        exp_t        ent;
        for (int p = 0; p < 2; p++) begin
            v = p ? rsp1_valid : rsp0_valid;
            e = p ? rsp1_err : rsp0_err;
            d = p ? rsp1_rdata : rsp0_rdata;
            if (v) begin
                if (reset || exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: port %0d pulsed, expected no response (cycle %0d)", p, cyc);
                end else begin
                    ent = exp_q.pop_front();
                    chk("rsp_port", 64'(p), 64'(ent.port));
                    chk("rsp_latency", 64'(cyc), 64'(ent.gcyc + 2));
                    chk("rsp_rdata", d, ent.rdata);
                    chk("rsp_err", 64'(e), 64'(ent.err));
                end
            end else begin
                chk("rsp_idle", {63'd0, e} | d, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
        logic acc;
        acc = 1'b0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = (p == 0) ? req0_ready : req1_ready;
            step();
        end
        if (p == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        chk("grant_timeout", 64'(acc), 64'd1);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [63:0] a;
        int          r;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) step();
            r = $urandom_range(0, 9);
            if (r == 0) a = {$urandom, $urandom};
            else if (r == 1) a = 64'($urandom_range(128, 140));
            else if (r < 6) a = 64'($urandom_range(0, 7));
            else a = 64'($urandom_range(0, 127));
            drive_req(p, 1'($urandom), a, {$urandom, $urandom});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        load_en = 1'b0;
        step();
        reset = 1'b0;
        repeat (20) step();

        drive_req(0, 1'b1, 64'd10, 64'hDEAD);
        drive_req(0, 1'b0, 64'd10, 64'd0);
        repeat (3) step();
        chk("ram10_store", ram[10], 64'hDEAD);

        fork
            begin drive_req(0, 1'b0, 64'd5, 64'd0); drive_req(0, 1'b0, 64'd5, 64'd0); end
            begin drive_req(1, 1'b0, 64'd6, 64'd0); drive_req(1, 1'b0, 64'd6, 64'd0); end
        join
        repeat (3) step();

        drive_req(1, 1'b0, 64'd200, 64'd0);
        drive_req(1, 1'b1, 64'd200, 64'h5555);
        drive_req(1, 1'b0, 64'd127, 64'd0);
        repeat (3) step();

        drive_req(0, 1'b1, 64'd3, 64'h1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
        chk("ram3_after_reset", ram[3], 64'd300);
        drive_req(0, 1'b0, 64'd3, 64'd0);
        repeat (3) step();

        drive_req(0, 1'b0, 64'd20, 64'd0);
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 64'd21; req1_wdata = 64'hBAD;
        step();
        req1_valid = 1'b0;
        repeat (3) step();
        fork
            drive_req(0, 1'b0, 64'd22, 64'd0);
            drive_req(1, 1'b0, 64'd23, 64'd0);
        join
        repeat (3) step();

        fork
            rand_port(0, 80);
            rand_port(1, 80);
        join
        repeat (6) step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < RAM_DEPTH; i++) chk("ram_contents", ram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
